// File: rtl/bsg_down_ch_ctrl_if.sv
// Signal bundle between the downstream channel controller, the link pins,
// the word buffer and the core. Stats ports appear with BSG_DOWN_CTRL_STATS_EN.
interface bsg_down_ch_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              io_valid_in;
    logic [7:0]        io_data_in;
    logic              io_token_out;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [15:0]       buf_wdata;
    logic [ADDR_W-1:0] buf_raddr;
    logic [15:0]       buf_rdata;
    logic              core_ready;
    logic              core_valid_out;
    logic [31:0]       core_data_out;
    logic              full;
    logic              empty;
    logic              overflow_err;
`ifdef BSG_DOWN_CTRL_STATS_EN
    logic [31:0]       stat_words_in;
    logic [31:0]       stat_words_out;
    logic [15:0]       stat_drops;

    modport master (
        output io_valid_in, io_data_in, buf_rdata, core_ready,
        input  io_token_out, buf_we, buf_waddr, buf_wdata, buf_raddr,
               core_valid_out, core_data_out, full, empty, overflow_err,
               stat_words_in, stat_words_out, stat_drops
    );

    modport slave (
        input  io_valid_in, io_data_in, buf_rdata, core_ready,
        output io_token_out, buf_we, buf_waddr, buf_wdata, buf_raddr,
               core_valid_out, core_data_out, full, empty, overflow_err,
               stat_words_in, stat_words_out, stat_drops
    );
`else
    modport master (
        output io_valid_in, io_data_in, buf_rdata, core_ready,
        input  io_token_out, buf_we, buf_waddr, buf_wdata, buf_raddr,
               core_valid_out, core_data_out, full, empty, overflow_err
    );

    modport slave (
        input  io_valid_in, io_data_in, buf_rdata, core_ready,
        output io_token_out, buf_we, buf_waddr, buf_wdata, buf_raddr,
               core_valid_out, core_data_out, full, empty, overflow_err
    );
`endif
endinterface

// File: rtl/bsg_down_ch_ctrl.sv
// Downstream channel buffer controller: byte->word packing on the write side,
// word-pair->32b assembly on the read side, token return. Optional stats: BSG_DOWN_CTRL_STATS_EN.
module bsg_down_ch_ctrl #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TOKEN_BATCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    bsg_down_ch_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned TOK_W = $clog2(TOKEN_BATCH + 1);

    typedef enum logic {WPH_HI = 1'b0, WPH_LO = 1'b1} wphase_e;
    typedef enum logic {RPH_HI = 1'b0, RPH_LO = 1'b1} rphase_e;

    wphase_e          wphase_q, wphase_d;
    rphase_e          rphase_q, rphase_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [7:0]       byte_q, byte_d;
    logic [15:0]      half_q, half_d;
    logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
    logic             token_q, token_d;
    logic             cvalid_q, cvalid_d;
    logic [31:0]      cdata_q, cdata_d;
    logic             ovf_q, ovf_d;

    logic full_c, empty_c, wr_fire_c, drop_c, rd_fire_c;

    // Status is derived from pre-cycle pointers, so a same-cycle read never rescues a write.
    assign empty_c   = (wptr_q == rptr_q);
    assign full_c    = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                       (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign wr_fire_c = bus.io_valid_in && (wphase_q == WPH_LO) && !full_c;
    assign drop_c    = bus.io_valid_in && (wphase_q == WPH_LO) && full_c;
    assign rd_fire_c = bus.core_ready && !empty_c;

    assign bus.full           = full_c;
    assign bus.empty          = empty_c;
    assign bus.buf_we         = wr_fire_c;
    assign bus.buf_waddr      = wptr_q[ADDR_W-1:0];
    assign bus.buf_wdata      = {byte_q, bus.io_data_in};
    assign bus.buf_raddr      = rptr_q[ADDR_W-1:0];
    assign bus.io_token_out   = token_q;
    assign bus.core_valid_out = cvalid_q;
    assign bus.core_data_out  = cdata_q;
    assign bus.overflow_err   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wphase_q  <= WPH_HI;
            rphase_q  <= RPH_HI;
            wptr_q    <= '0;
            rptr_q    <= '0;
            byte_q    <= '0;
            half_q    <= '0;
            tok_cnt_q <= '0;
            token_q   <= 1'b0;
            cvalid_q  <= 1'b0;
            cdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wphase_q  <= wphase_d;
            rphase_q  <= rphase_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            byte_q    <= byte_d;
            half_q    <= half_d;
            tok_cnt_q <= tok_cnt_d;
            token_q   <= token_d;
            cvalid_q  <= cvalid_d;
            cdata_q   <= cdata_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        wphase_d  = wphase_q;
        rphase_d  = rphase_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        byte_d    = byte_q;
        half_d    = half_q;
        tok_cnt_d = tok_cnt_q;
        token_d   = 1'b0;
        cvalid_d  = 1'b0;
        cdata_d   = cdata_q;
        ovf_d     = ovf_q;

        if (bus.io_valid_in) begin
            if (wphase_q == WPH_HI) begin
                byte_d   = bus.io_data_in;
                wphase_d = WPH_LO;
            end else begin
                wphase_d = WPH_HI;
                if (full_c) begin
                    ovf_d = 1'b1;
                end else begin
                    wptr_d = wptr_q + PTR_W'(1);
                end
            end
        end

        if (rd_fire_c) begin
            rptr_d = rptr_q + PTR_W'(1);
            if (rphase_q == RPH_HI) begin
                half_d   = bus.buf_rdata;
                rphase_d = RPH_LO;
            end else begin
                cdata_d  = {half_q, bus.buf_rdata};
                cvalid_d = 1'b1;
                rphase_d = RPH_HI;
            end
            // One credit per TOKEN_BATCH words freed.
            if (tok_cnt_q == TOK_W'(TOKEN_BATCH - 1)) begin
                token_d   = 1'b1;
                tok_cnt_d = '0;
            end else begin
                tok_cnt_d = tok_cnt_q + TOK_W'(1);
            end
        end
    end

`ifdef BSG_DOWN_CTRL_STATS_EN
    logic [31:0] words_in_q, words_out_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_in_q  <= '0;
            words_out_q <= '0;
            drops_q     <= '0;
        end else begin
            if (wr_fire_c) words_in_q <= words_in_q + 32'(1);
            if (cvalid_d) words_out_q <= words_out_q + 32'(1);
            if (drop_c && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'(1);
        end
    end

    assign bus.stat_words_in  = words_in_q;
    assign bus.stat_words_out = words_out_q;
    assign bus.stat_drops     = drops_q;
`else
    logic unused_drop_c;
    assign unused_drop_c = drop_c;
`endif

endmodule
